// File: rtl/sim_ctrl_wb.sv
// ---------------------------------------------------------------------------
// sim_ctrl_wb
//
// Wishbone B3 classic slave on the OR1200 data bus. It gives software running
// on the core a path back to the simulation bench. It provides:
//   - an exit register that latches a pass/fail code once,
//   - a 16-deep character FIFO that the bench drains with valid/ready,
//   - a 64-bit free-running cycle counter with a consistent hi/lo read,
//   - a watchdog that flags a hung test.
//
// Register map (byte offsets; wb_adr_i[1:0] ignored):
//   0x00 EXIT      RW  full-select write latches exit_code_o, sets done_o
//   0x04 TXDATA    WO  sel[0] write pushes wb_dat_i[7:0], stalls while full
//   0x08 CYCLE_LO  RO  counter[31:0], snapshots counter[63:32]
//   0x0C CYCLE_HI  RO  snapshot of counter[63:32]
//   0x10 WDOG      RW  watchdog count, 0 disables
//   0x14 STATUS    RO  [FIFO_AW:0] level, [8] full, [9] empty,
//                      [16] done, [17] timeout
//
// Ports:
//   wb_clk_i / wb_rst_n_i     single clock, synchronous active-low reset
//   wb_adr_i .. wb_bte_i      Wishbone slave inputs (cti/bte ignored)
//   wb_dat_o, wb_ack_o,
//   wb_err_o, wb_rty_o        Wishbone slave outputs (rty tied low)
//   char_valid_o/_data_o      FIFO head toward the bench
//   char_ready_i              bench accepts the head byte
//   done_o, exit_code_o       sticky exit indication and code
//   timeout_o                 sticky watchdog expiry
//
// CYCLE_INIT is the counter value loaded at reset. Leave it at 0 in real
// use; a nonzero value lets a simulation reach the 32-bit carry quickly.
// ---------------------------------------------------------------------------
module sim_ctrl_wb #(
  parameter int          FIFO_AW    = 4,
  parameter int          WDOG_W     = 32,
  parameter logic [63:0] CYCLE_INIT = 64'h0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [7:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic        char_valid_o,
  output logic [7:0]  char_data_o,
  input  logic        char_ready_i,
  output logic        done_o,
  output logic [31:0] exit_code_o,
  output logic        timeout_o
);

  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [5:0] REG_EXIT   = 6'h00;
  localparam logic [5:0] REG_TXDATA = 6'h01;
  localparam logic [5:0] REG_CYC_LO = 6'h02;
  localparam logic [5:0] REG_CYC_HI = 6'h03;
  localparam logic [5:0] REG_WDOG   = 6'h04;
  localparam logic [5:0] REG_STATUS = 6'h05;

  // Bus handshake state
  logic              pend_q, pend_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [31:0]       dat_q, dat_d;

  // Service state
  logic              done_q, done_d;
  logic [31:0]       exit_q, exit_d;
  logic              timeout_q, timeout_d;
  logic [63:0]       cnt_q, cnt_d;
  logic [31:0]       shadow_q, shadow_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  // Character FIFO
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;

  logic        bus_req, capture, commit;
  logic        full, empty, pop;
  logic        term_ok, term_err, stall;
  logic        exit_wr, push, wdog_wr, snap;
  logic        wdog_dec, expire;
  logic [31:0] rdata, status;
  logic [5:0]  reg_idx;

  // cti/bte and the byte lane bits of the address carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{wb_cti_i, wb_bte_i, wb_adr_i[1:0]};

  assign bus_req = wb_cyc_i & wb_stb_i;
  // A new access may be captured in the cycle its predecessor is acked; the
  // commit on the following edge then leaves the one idle cycle between
  // terminations, so a held strobe is answered every other cycle.
  assign capture = bus_req & ~pend_q;
  // A pending access whose strobe has dropped simply falls out of pend_q.
  assign commit  = bus_req & pend_q;
  assign reg_idx = wb_adr_i[7:2];

  assign full  = (level_q == (FIFO_AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign pop   = ~empty & char_ready_i;

  always_comb begin : status_word
    status             = '0;
    status[FIFO_AW:0]  = level_q;
    status[8]          = full;
    status[9]          = empty;
    status[16]         = done_q;
    status[17]         = timeout_q;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin : decode
    term_ok  = 1'b0;
    term_err = 1'b0;
    stall    = 1'b0;
    rdata    = '0;
    exit_wr  = 1'b0;
    push     = 1'b0;
    wdog_wr  = 1'b0;
    snap     = 1'b0;
    if (commit) begin
      case (reg_idx)
        REG_EXIT: begin
          if (!wb_we_i) begin
            term_ok = 1'b1;
            rdata   = exit_q;
          end else if (wb_sel_i == 4'hF) begin
            term_ok = 1'b1;
            exit_wr = ~done_q;   // only the first full write sticks
          end else begin
            term_err = 1'b1;
          end
        end
        REG_TXDATA: begin
          if (wb_we_i && wb_sel_i[0] && full) begin
            stall = 1'b1;        // hold ack until a pop frees a slot
          end else begin
            term_ok = 1'b1;
            push    = wb_we_i & wb_sel_i[0];
          end
        end
        REG_CYC_LO: begin
          term_err = wb_we_i;
          term_ok  = ~wb_we_i;
          snap     = ~wb_we_i;
          rdata    = cnt_q[31:0];
        end
        REG_CYC_HI: begin
          term_err = wb_we_i;
          term_ok  = ~wb_we_i;
          rdata    = shadow_q;
        end
        REG_WDOG: begin
          term_ok = 1'b1;
          wdog_wr = wb_we_i;
          rdata   = 32'(wdog_q);
        end
        REG_STATUS: begin
          term_err = wb_we_i;
          term_ok  = ~wb_we_i;
          rdata    = status;
        end
        default: term_err = 1'b1;
      endcase
    end
  end

  always_comb begin : next_state
    pend_d = capture | stall;
    ack_d  = term_ok;
    err_d  = term_err;
    dat_d  = term_ok ? rdata : '0;

    exit_d = exit_wr ? wb_dat_i : exit_q;
    done_d = done_q | exit_wr;

    // A load in the same cycle overrides the decrement, and an EXIT landing
    // on the expiry edge means the test finished: no timeout in either case.
    wdog_dec  = (wdog_q != '0) & ~done_q;
    expire    = wdog_dec & (wdog_q == WDOG_W'(1)) & ~wdog_wr & ~exit_wr;
    timeout_d = timeout_q | expire;
    if (wdog_wr)       wdog_d = wb_dat_i[WDOG_W-1:0];
    else if (wdog_dec) wdog_d = wdog_q - WDOG_W'(1);
    else               wdog_d = wdog_q;

    cnt_d    = (done_q | timeout_q) ? cnt_q : cnt_q + 64'd1;
    shadow_d = snap ? cnt_q[63:32] : shadow_q;

    wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (FIFO_AW+1)'(1);
      2'b01:   level_d = level_q - (FIFO_AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the values from before this edge.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      pend_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= '0;
      done_q    <= 1'b0;
      exit_q    <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= CYCLE_INIT;
      shadow_q  <= '0;
      wdog_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
    end else begin
      pend_q    <= pend_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      dat_q     <= dat_d;
      done_q    <= done_d;
      exit_q    <= exit_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      wdog_q    <= wdog_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; the pointers and level
  // define what is valid, and the head output is masked while empty.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_n_i && push) mem[wr_ptr_q] <= wb_dat_i[7:0];
  end

  assign wb_dat_o     = dat_q;
  assign wb_ack_o     = ack_q;
  assign wb_err_o     = err_q;
  assign wb_rty_o     = 1'b0;
  assign char_valid_o = ~empty;
  assign char_data_o  = empty ? 8'h00 : mem[rd_ptr_q];
  assign done_o       = done_q;
  assign exit_code_o  = exit_q;
  assign timeout_o    = timeout_q;

endmodule

// File: doc/sim_ctrl_wb.md
# sim_ctrl_wb

Wishbone B3 slave that lets software running on the OR1200 talk back to the simulation bench, in the opposite direction to the bench's memory preload and instruction monitor. It sits on the data bus of `orpsoc_top` and provides four services to the bench:
- an exit/pass-fail register;
- a character output FIFO drained by the bench over a valid/ready handshake;
- a 64-bit cycle counter;
- a watchdog that flags a hung test.

## Interface
- `FIFO_AW`, 4 — log2 of char FIFO depth (depth 16).
- `WDOG_W`, 32 — watchdog counter width (≤32).

Ports:
- `wb_clk_i` in 1 — the single clock.
- `wb_rst_n_i` in 1 — reset; one clock, synchronous, active-low.
- `wb_adr_i` in 8 — byte address; bits [1:0] ignored.
- `wb_dat_i` in 32 — write data.
- `wb_sel_i` in 4 — byte selects.
- `wb_we_i`, `wb_cyc_i`, `wb_stb_i` in 1 — classic-cycle controls.
- `wb_cti_i` in 3, `wb_bte_i` in 2 — ignored; every access is treated as classic.
- `wb_dat_o` out 32 — read data, valid while `wb_ack_o` = 1.
- `wb_ack_o`, `wb_err_o` out 1 — termination.
- `wb_rty_o` out 1 — tied 0.
- `char_valid_o` out 1 — FIFO head valid.
- `char_data_o` out 8 — FIFO head byte.
- `char_ready_i` in 1 — bench accepts the head byte.
- `done_o` out 1 — sticky; software wrote EXIT.
- `exit_code_o` out 32 — value written to EXIT.
- `timeout_o` out 1 — sticky; watchdog expired.

## Operation
Register map (byte offsets). Any other offset, or a write to a read-only register, terminates with err.
- 0x00 EXIT (RW)
  - Write with `wb_sel_i` = 4'hF: `exit_code_o` ← data, `done_o` ← 1.
  - Only the first write takes effect; later writes are acked and ignored.
  - A partial-select write returns err.
  - Read returns `exit_code_o`.
- 0x04 TXDATA (WO-ish)
  - Write with `wb_sel_i[0]` = 1 pushes `wb_dat_i[7:0]`.
  - Write with `wb_sel_i[0]` = 0 is acked with no push.
  - Read returns 0.
- 0x08 CYCLE_LO (RO)
  - Returns counter[31:0].
  - Snapshots counter[63:32] into a shadow register in the same cycle.
- 0x0C CYCLE_HI (RO): returns the shadow register, not the live upper half.
- 0x10 WDOG (RW)
  - Write loads the count; 0 disables the watchdog.
  - Read returns the live count, zero-extended.
- 0x14 STATUS (RO)
  - [FIFO_AW:0] fill level.
  - [8] full; [9] empty.
  - [16] done; [17] timeout.

Cycle counter:
- 64-bit, cleared at reset, +1 per cycle.
- Wraps at 2^64.
- Freezes once `done_o` or `timeout_o` = 1.

Watchdog:
- While nonzero and `done_o` = 0, decrements each cycle.
- The 1→0 transition sets `timeout_o`.
- A WDOG write in the same cycle as a decrement wins: the loaded value is taken.

Char FIFO:
- Depth 2^FIFO_AW.
- `char_valid_o` = not empty; `char_data_o` = head.
- Pop on `char_valid_o` & `char_ready_i`.
- TXDATA write while full stalls: ack is withheld until a pop frees a slot; then push and ack.
- Push and pop in the same cycle leave the level unchanged.

## Timing
Reset values:
- `wb_ack_o` = `wb_err_o` = `wb_rty_o` = 0; `wb_dat_o` = 0.
- `char_valid_o` = 0; `char_data_o` = 0.
- `done_o` = 0; `exit_code_o` = 0; `timeout_o` = 0.
- Counter = 0, watchdog = 0, FIFO empty.

Bus access:
- Access seen at edge N (`cyc` & `stb`, no ack/err pending). `wb_ack_o` or `wb_err_o` is high for exactly one cycle after edge N+1.
- Register side effects commit on that same edge.
- Ack/err are always deasserted for at least one cycle between terminations, so a held `stb` is terminated every other cycle.
- If `cyc` or `stb` drops before termination, the pending access is abandoned with no side effect.
- A stalled TXDATA write acks on the edge after the freeing pop.

Outputs and simultaneous events:
- `done_o`, `timeout_o` and `exit_code_o` change on the write or expiry edge and hold until reset.
- EXIT write and watchdog expiry on the same edge: `done_o` = 1, `timeout_o` stays 0.
- Reset asserted mid-access: ack is never issued; all state returns to reset values on that edge.

## Test plan
- Reset, then read STATUS → ack one cycle after `stb`, data 0x0000_0200 (empty), `char_valid_o` = 0.
- Write 0x41, 0x42 to TXDATA with `char_ready_i` = 0 → `char_valid_o` = 1, `char_data_o` = 0x41. Raise ready for 2 cycles → 0x41 then 0x42 popped, FIFO empty.
- With ready held 0, write 17 bytes → first 16 acked, 17th stalls. One pop → 17th acked on the next edge, level = 16.
- Write WDOG = 5, no EXIT → `timeout_o` = 1 exactly 5 cycles after the write ack, counter frozen. Repeat with EXIT written at the expiry edge → `done_o` = 1, `timeout_o` = 0.
- Write EXIT 0x0000_0001, then 0xDEAD_BEEF → `exit_code_o` stays 0x1. Partial-select write to EXIT and read of offset 0x18 → `wb_err_o` pulses, no state change.
- Preload counter near 0x0000_0000_FFFF_FFFF (run 2^32 cycles or force) → CYCLE_LO read then CYCLE_HI read give a consistent 64-bit pair across the carry.
